// File: rtl/stepper_pulse_dist_p.sv
// PHASES-phase stepper pulse distributor with a step-rate prescaler and a step-count move.
// All state updates on the falling edge of CP. CR is a synchronous, active-low reset.
module stepper_pulse_dist_p #(
  parameter int PHASES = 3,
  parameter int DIV_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                            CP,
  input  logic                            CR,
  input  logic                            M,
  input  logic [1:0]                      MODE,
  input  logic                            EN,
  input  logic                            START,
  input  logic                            STOP,
  input  logic [DIV_W-1:0]                DIV,
  input  logic [CNT_W-1:0]                STEPS,
  output logic [PHASES-1:0]               phase,
  output logic [$clog2(2*PHASES)-1:0]     idx,
  output logic [CNT_W-1:0]                remaining,
  output logic                            busy,
  output logic                            done
);

  localparam int L     = 2 * PHASES;
  localparam int IDX_W = $clog2(L);
  localparam logic [IDX_W:0] L_EXT = (IDX_W+1)'(L);
  localparam logic [IDX_W-1:0] LAST_PHASE = IDX_W'(PHASES - 1);
  localparam logic [PHASES-1:0] PHASE_RST = {1'b1, {(PHASES-1){1'b0}}};

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_RUN  = 1'b1;

  logic [0:0]        state_q,     state_d;
  logic [IDX_W-1:0]  idx_q,       idx_d;
  logic [PHASES-1:0] phase_q,     phase_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [DIV_W-1:0]  presc_q,     presc_d;
  logic [DIV_W-1:0]  div_q,       div_d;
  logic              done_q,      done_d;

  logic [IDX_W:0]    step_amt;
  logic [IDX_W:0]    idx_sum;
  logic [IDX_W:0]    idx_fwd;
  logic [IDX_W:0]    idx_rev;
  logic [IDX_W-1:0]  idx_step;

  // Single mode lands on even indices, double on odd: a 2-step jump is
  // taken only when already aligned, otherwise a 1-step realigns.
  always_comb begin
    step_amt = (IDX_W+1)'(1);
    if (!MODE[1] && (MODE[0] == idx_q[0])) begin
      step_amt = (IDX_W+1)'(2);
    end
    idx_sum = {1'b0, idx_q} + step_amt;
    idx_fwd = (idx_sum >= L_EXT) ? (idx_sum - L_EXT) : idx_sum;
    idx_rev = ({1'b0, idx_q} >= step_amt) ? ({1'b0, idx_q} - step_amt)
                                           : ({1'b0, idx_q} + L_EXT - step_amt);
    idx_step = M ? idx_fwd[IDX_W-1:0] : idx_rev[IDX_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    remaining_d = remaining_q;
    presc_d     = presc_q;
    div_d       = div_q;
    done_d      = 1'b0;

    if (state_q == STATE_IDLE) begin
      if (!STOP && START) begin
        if (STEPS != '0) begin
          remaining_d = STEPS;
          presc_d     = '0;
          div_d       = DIV;
          state_d     = STATE_RUN;
        end else begin
          done_d = 1'b1;
        end
      end
    end else begin
      if (STOP) begin
        state_d     = STATE_IDLE;
        remaining_d = '0;
        presc_d     = '0;
      end else if (EN) begin
        if (presc_q == div_q) begin
          presc_d     = '0;
          idx_d       = idx_step;
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = STATE_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end
    end
  end

  // Decode of the next index so phase and idx register on the same edge.
  // Bit of S(k) is (k-1) mod PHASES; bit of S(k+1) is k.
  logic [IDX_W-1:0] k_d;
  logic [IDX_W-1:0] pos_a_d;

  always_comb begin
    k_d     = idx_d >> 1;
    pos_a_d = (k_d == '0) ? LAST_PHASE : (k_d - IDX_W'(1));
  end

  generate
    for (genvar gi = 0; gi < PHASES; gi++) begin : g_phase
      assign phase_d[gi] = (pos_a_d == IDX_W'(gi)) || (idx_d[0] && (k_d == IDX_W'(gi)));
    end
  endgenerate

  always_ff @(negedge CP) begin
    if (!CR) begin
      state_q     <= STATE_IDLE;
      idx_q       <= '0;
      phase_q     <= PHASE_RST;
      remaining_q <= '0;
      presc_q     <= '0;
      div_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      remaining_q <= remaining_d;
      presc_q     <= presc_d;
      div_q       <= div_d;
      done_q      <= done_d;
    end
  end

  assign phase     = phase_q;
  assign idx       = idx_q;
  assign remaining = remaining_q;
  assign busy      = (state_q == STATE_RUN);
  assign done      = done_q;

endmodule

// File: doc/stepper_pulse_dist_p.md
Name: stepper_pulse_dist_p

Overview:
Parametrised successor to the team's fixed 3-phase, six-beat stepper pulse distributor. It generates phase-drive patterns for a PHASES-phase stepper in single-phase, double-phase or half-step excitation, in either direction. It adds an on-chip step-rate prescaler, a programmable step-count move with busy/done handshake, pause and abort. It sits between the motion-control logic and the phase driver outputs.

Parameters:
PHASES, 3, number of motor phases (>=3); sequence length L = 2*PHASES
DIV_W, 16, prescaler width; step period = DIV+1 CP cycles
CNT_W, 16, width of step-count request and remaining counter

Ports:
CP  in  1  clock; all state updates on the falling edge of CP
CR  in  1  reset, synchronous, active-low, sampled on the CP falling edge
M  in  1  direction: 1 = forward (index +), 0 = reverse (index -)
MODE  in  2  00 single-phase, 01 double-phase, 10 half-step, 11 treated as half-step
EN  in  1  1 = run; 0 = pause (prescaler and stepping frozen, phases held energised)
START  in  1  start a move; honoured only when idle
STOP  in  1  abort the current move
DIV  in  DIV_W  step period minus one
STEPS  in  CNT_W  number of steps for the move
phase  out  PHASES  phase drive pattern, registered
idx  out  clog2(L)  current sequence index 0..L-1
remaining  out  CNT_W  steps left in the current move
busy  out  1  move in progress
done  out  1  one-cycle pulse on normal move completion

Behaviour:
- Reset (CR=0 at a falling edge) dominates all inputs. It sets idx=0, phase=1<<(PHASES-1), busy=0, done=0, remaining=0, prescaler=0. Reset mid-move aborts without a done pulse.
- Pattern from idx: let k=idx>>1. Single pattern S(k) = (1<<(PHASES-1)) rotated left by k (mod PHASES). Even idx gives phase=S(k); odd idx gives phase=S(k)|S(k+1 mod PHASES).
- For PHASES=3 the forward half-step sequence is 100,101,001,011,010,110. This is backward compatible with the existing block.
- phase is always the registered decode of idx; both update on the same edge.
- States: IDLE (busy=0), RUN (busy=1).
- IDLE: START=1 with STEPS>0 loads remaining=STEPS, clears the prescaler and enters RUN.
- IDLE: START=1 with STEPS=0 pulses done=1 for one cycle; busy stays 0 and there is no motion.
- START while busy is ignored.
- RUN, EN=1: the prescaler increments each edge. When the prescaler equals DIV, a step tick occurs and the prescaler returns to 0. First step occurs DIV+1 edges after the START edge.
- RUN, EN=0: prescaler, idx and remaining all hold.
- On a step tick, M and MODE are sampled on that edge:
  - half-step: idx±1 mod L.
  - single: if idx even, idx±2 mod L; if odd, idx±1 to reach even.
  - double: if idx odd, idx±2 mod L; if even, idx±1 to reach odd.
  - Each tick also decrements remaining by 1.
- Final tick (remaining=1): on the same edge idx advances, remaining=0, busy=0, done=1 (one cycle) and the FSM returns to IDLE.
- STOP=1 in RUN: return to IDLE next edge. idx and phase are held, remaining is cleared, prescaler cleared, no done pulse.
- STOP has priority over a coincident tick; no step is issued on that edge.
- STOP in IDLE has no effect. START and STOP together in IDLE: STOP wins, no move starts.
- DIV and STEPS are sampled only at START (DIV is latched internally). Changes mid-move have no effect.
- Wrap-around: idx L-1 +1 gives 0, and 0 -1 gives L-1, in all modes.

Test Plan:
1. Reset, PHASES=3, MODE=10, M=1, DIV=0, START with STEPS=6 -> phase 101,001,011,010,110,100 on consecutive edges; busy high 6 cycles; done pulses on the 6th step edge; remaining 6→0.
2. From reset, MODE=10, M=0, STEPS=2, DIV=0 -> phase 110 then 010; idx 5 then 4 (wrap from 0).
3. From reset, MODE=00, M=1, DIV=3, STEPS=3 -> steps every 4 edges; phase 001,010,100; idx 2,4,0.
4. From reset, MODE=01, M=1, STEPS=3 -> idx 1,3,5; phase 101,011,110. Then MODE=00 with STEPS=1 -> idx 0, phase 100.
5. Run STEPS=10, DIV=1: drop EN for 5 cycles after step 3 -> idx and remaining=7 frozen. Assert STOP after step 5 -> busy=0, no done, phase held. A second run with CR=0 mid-move -> phase 100, idx 0, busy 0.
6. START with STEPS=0 -> done=1 for one cycle, busy never set. START pulsed while busy -> ignored, remaining unchanged.
